// File: rtl/arya_pkg.sv
// Shared defaults and helpers for the multithreaded fetch scheduler.
// Keep this package free of any design state so every block can import it.
package arya_pkg;

  localparam int DEFAULT_THREAD_BITS     = 2;
  localparam int DEFAULT_NUM_THREADS     = 1 << DEFAULT_THREAD_BITS;
  localparam int DEFAULT_INST_ADDR_WIDTH = 9;

  // Each thread starts in its own equal slice of instruction memory.
  function automatic int thread_base_pc(input int idx, input int thread_bits,
                                        input int addr_width);
    return idx << (addr_width - thread_bits);
  endfunction

endpackage

// File: rtl/thread_fetch_scheduler_rr_arbiter.sv
// Combinational rotate-priority encoder: the first requester after `last`
// (wrapping) wins; `last` itself has the lowest priority.
module rr_arbiter #(
  parameter int N  = 4,
  parameter int LW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [LW-1:0] last,
  output logic          gnt_valid,
  output logic [LW-1:0] gnt_idx
);

  logic [LW-1:0] cand;

  // Walk from the farthest offset to the nearest so the nearest hit is kept.
  always_comb begin
    gnt_valid = 1'b0;
    gnt_idx   = '0;
    cand      = '0;
    for (int k = N; k >= 1; k--) begin
      cand = LW'((int'(last) + k) % N);
      if (req[cand]) begin
        gnt_valid = 1'b1;
        gnt_idx   = cand;
      end
    end
  end

endmodule

// File: rtl/thread_fetch_scheduler.sv
// Fine-grained multithreaded fetch scheduler: one PC per hardware thread,
// round-robin issue of one eligible thread per cycle, with redirect support.
module thread_fetch_scheduler
  import arya_pkg::*;
#(
  parameter int THREAD_BITS     = DEFAULT_THREAD_BITS,
  parameter int INST_ADDR_WIDTH = DEFAULT_INST_ADDR_WIDTH
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [(1<<THREAD_BITS)-1:0] thread_enable,
  input  logic [(1<<THREAD_BITS)-1:0] thread_block,
  input  logic                       stall,
  input  logic                       redirect_valid,
  input  logic [THREAD_BITS-1:0]     redirect_thread,
  input  logic [INST_ADDR_WIDTH-1:0] redirect_pc,
  output logic                       fetch_valid,
  output logic [THREAD_BITS-1:0]     fetch_thread_id,
  output logic [INST_ADDR_WIDTH-1:0] fetch_pc,
  output logic                       pipe_en
);

  localparam int NUM_THREADS = 1 << THREAD_BITS;

  logic [INST_ADDR_WIDTH-1:0] pc_q    [NUM_THREADS];
  logic [INST_ADDR_WIDTH-1:0] pc_d    [NUM_THREADS];
  logic [INST_ADDR_WIDTH-1:0] base_pc [NUM_THREADS];

  logic [THREAD_BITS-1:0]     last_grant_q, last_grant_d;
  logic                       fetch_valid_q, fetch_valid_d;
  logic [THREAD_BITS-1:0]     fetch_thread_id_q, fetch_thread_id_d;
  logic [INST_ADDR_WIDTH-1:0] fetch_pc_q, fetch_pc_d;

  logic [NUM_THREADS-1:0]     eligible;
  logic                       gnt_valid;
  logic [THREAD_BITS-1:0]     gnt_idx;
  logic                       issue;
  logic [INST_ADDR_WIDTH-1:0] issue_pc;

  for (genvar gi = 0; gi < NUM_THREADS; gi++) begin : g_base
    assign base_pc[gi] =
      INST_ADDR_WIDTH'(thread_base_pc(gi, THREAD_BITS, INST_ADDR_WIDTH));
  end

  assign eligible = thread_enable & ~thread_block;

  rr_arbiter #(
    .N  (NUM_THREADS),
    .LW (THREAD_BITS)
  ) u_arb (
    .req       (eligible),
    .last      (last_grant_q),
    .gnt_valid (gnt_valid),
    .gnt_idx   (gnt_idx)
  );

  assign issue    = gnt_valid & ~stall;
  // A same-cycle redirect to the granted thread beats its stored PC.
  assign issue_pc = (redirect_valid && (redirect_thread == gnt_idx))
                    ? redirect_pc : pc_q[gnt_idx];

  always_comb begin
    for (int i = 0; i < NUM_THREADS; i++) begin
      pc_d[i] = pc_q[i];
    end
    last_grant_d      = last_grant_q;
    fetch_valid_d     = fetch_valid_q;
    fetch_thread_id_d = fetch_thread_id_q;
    fetch_pc_d        = fetch_pc_q;

    if (redirect_valid) begin
      pc_d[redirect_thread] = redirect_pc;
    end

    if (issue) begin
      fetch_valid_d     = 1'b1;
      fetch_thread_id_d = gnt_idx;
      fetch_pc_d        = issue_pc;
      pc_d[gnt_idx]     = issue_pc + INST_ADDR_WIDTH'(1);
      last_grant_d      = gnt_idx;
    end else if (!stall) begin
      fetch_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_THREADS; i++) begin
        pc_q[i] <= base_pc[i];
      end
      last_grant_q      <= THREAD_BITS'(NUM_THREADS - 1);
      fetch_valid_q     <= 1'b0;
      fetch_thread_id_q <= '0;
      fetch_pc_q        <= '0;
    end else begin
      for (int i = 0; i < NUM_THREADS; i++) begin
        pc_q[i] <= pc_d[i];
      end
      last_grant_q      <= last_grant_d;
      fetch_valid_q     <= fetch_valid_d;
      fetch_thread_id_q <= fetch_thread_id_d;
      fetch_pc_q        <= fetch_pc_d;
    end
  end

  assign fetch_valid     = fetch_valid_q;
  assign fetch_thread_id = fetch_thread_id_q;
  assign fetch_pc        = fetch_pc_q;
  assign pipe_en         = ~stall & ~reset;

endmodule

// File: tb/tb_thread_fetch_scheduler.sv
// Bench for thread_fetch_scheduler: a queue-free behavioural model checked
// every cycle, plus directed literal expectations along the test plan.
module tb_thread_fetch_scheduler;

  localparam int TB  = 2;
  localparam int NT  = 4;
  localparam int AW  = 9;

  logic          clk = 1'b0;
  logic          reset;
  logic [NT-1:0] thread_enable;
  logic [NT-1:0] thread_block;
  logic          stall;
  logic          redirect_valid;
  logic [TB-1:0] redirect_thread;
  logic [AW-1:0] redirect_pc;
  logic          fetch_valid;
  logic [TB-1:0] fetch_thread_id;
  logic [AW-1:0] fetch_pc;
  logic          pipe_en;

  int n_cmp = 0;
  int n_bad = 0;

  thread_fetch_scheduler #(.THREAD_BITS(TB), .INST_ADDR_WIDTH(AW)) dut (
    .clk             (clk),
    .reset           (reset),
    .thread_enable   (thread_enable),
    .thread_block    (thread_block),
    .stall           (stall),
    .redirect_valid  (redirect_valid),
    .redirect_thread (redirect_thread),
    .redirect_pc     (redirect_pc),
    .fetch_valid     (fetch_valid),
    .fetch_thread_id (fetch_thread_id),
    .fetch_pc        (fetch_pc),
    .pipe_en         (pipe_en)
  );

  always #5 clk = ~clk;

  // Model state in plain integers.
  int  m_pc [NT];
  int  m_last;
  int  m_fv, m_fid, m_fpc;
  bit  m_init = 1'b0;

  always @(posedge clk) begin
    int g, ip;
    if (reset) begin
      for (int i = 0; i < NT; i++) m_pc[i] = i * (1 << (AW - TB));
      m_last = NT - 1; m_fv = 0; m_fid = 0; m_fpc = 0; m_init = 1'b1;
    end else if (m_init) begin
      g = -1;
      for (int k = 1; k <= NT; k++) begin
        int idx;
        idx = (m_last + k) % NT;
        if (g < 0 && thread_enable[idx] && !thread_block[idx]) g = idx;
      end
      if (redirect_valid) m_pc[redirect_thread] = int'(redirect_pc);
      if (!stall && g >= 0) begin
        ip = m_pc[g];
        m_pc[g] = (ip + 1) % (1 << AW);
        m_fv = 1; m_fid = g; m_fpc = ip; m_last = g;
      end else if (!stall) begin
        m_fv = 0;
      end
    end
  end

  always @(negedge clk) begin
    if (m_init) begin
      n_cmp++;
      if (int'(fetch_valid) != m_fv || int'(fetch_thread_id) != m_fid ||
          int'(fetch_pc) != m_fpc || pipe_en != (!stall && !reset)) begin
        n_bad++;
        $display("FAIL model t=%0t got v=%0d id=%0d pc=%0d en=%0d want v=%0d id=%0d pc=%0d en=%0d",
                 $time, fetch_valid, fetch_thread_id, fetch_pc, pipe_en,
                 m_fv, m_fid, m_fpc, (!stall && !reset));
      end else begin
        $display("cycle t=%0t v=%0d id=%0d pc=%0d en=%0d", $time,
                 fetch_valid, fetch_thread_id, fetch_pc, pipe_en);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic lit(input string name, input int v, input int id, input int pc,
                     input int en);
    n_cmp++;
    if (int'(fetch_valid) != v || int'(fetch_thread_id) != id ||
        int'(fetch_pc) != pc || int'(pipe_en) != en) begin
      n_bad++;
      $display("FAIL %s got v=%0d id=%0d pc=%0d en=%0d want v=%0d id=%0d pc=%0d en=%0d",
               name, fetch_valid, fetch_thread_id, fetch_pc, pipe_en, v, id, pc, en);
    end
  endtask

  // Deterministic mixed-pattern vectors: {enable, block, stall, rv, rthread, rpc}
  typedef struct packed {
    logic [3:0] en; logic [3:0] blk; logic st; logic rv; logic [1:0] rt; logic [8:0] rp;
  } vec_t;
  vec_t vecs [12] = '{
    '{4'hF, 4'h0, 1'b0, 1'b0, 2'd0, 9'd0},
    '{4'hF, 4'h5, 1'b0, 1'b1, 2'd1, 9'd77},
    '{4'hA, 4'h2, 1'b0, 1'b0, 2'd0, 9'd0},
    '{4'hA, 4'h8, 1'b1, 1'b1, 2'd3, 9'd500},
    '{4'h6, 4'h0, 1'b0, 1'b1, 2'd2, 9'd300},
    '{4'h6, 4'h4, 1'b0, 1'b0, 2'd0, 9'd0},
    '{4'h0, 4'h0, 1'b0, 1'b1, 2'd0, 9'd42},
    '{4'h1, 4'h0, 1'b0, 1'b0, 2'd0, 9'd0},
    '{4'hF, 4'hF, 1'b0, 1'b0, 2'd0, 9'd0},
    '{4'hF, 4'h3, 1'b1, 1'b0, 2'd0, 9'd0},
    '{4'hF, 4'h3, 1'b0, 1'b1, 2'd3, 9'd511},
    '{4'hF, 4'h0, 1'b0, 1'b0, 2'd0, 9'd0}
  };

  initial begin
    #100000;
    $display("FAIL timeout reached");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1; thread_enable = '0; thread_block = '0; stall = 1'b0;
    redirect_valid = 1'b0; redirect_thread = '0; redirect_pc = '0;
    tick(); tick();
    lit("reset", 0, 0, 0, 0);

    // 1: plain round-robin from the reset bases
    reset = 1'b0; thread_enable = 4'hF;
    tick(); lit("rr0", 1, 0, 0, 1);
    tick(); lit("rr1", 1, 1, 128, 1);
    tick(); lit("rr2", 1, 2, 256, 1);
    tick(); lit("rr3", 1, 3, 384, 1);
    tick(); lit("rr4", 1, 0, 1, 1);
    tick(); lit("rr5", 1, 1, 129, 1);

    // 2: T1 blocked, then released at its held PC
    thread_block = 4'b0010;
    tick(); lit("blk0", 1, 2, 257, 1);
    tick(); lit("blk1", 1, 3, 385, 1);
    tick(); lit("blk2", 1, 0, 2, 1);
    tick(); lit("blk3", 1, 2, 258, 1);
    thread_block = 4'b0000;
    tick(); lit("rel0", 1, 3, 386, 1);
    tick(); lit("rel1", 1, 0, 3, 1);
    tick(); lit("rel2", 1, 1, 130, 1);

    // 3: three stalled cycles freeze everything
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick(); lit("stall", 1, 1, 130, 0);
    end
    stall = 1'b0;
    tick(); lit("post_stall", 1, 2, 259, 1);

    // 4: redirect T2 on its grant cycle, then again under stall
    tick(); tick(); tick(); lit("pre_redir", 1, 1, 131, 1);
    redirect_valid = 1'b1; redirect_thread = 2'd2; redirect_pc = 9'h1F0;
    tick(); lit("redir_grant", 1, 2, 9'h1F0, 1);
    redirect_valid = 1'b0;
    tick(); tick(); tick();
    tick(); lit("redir_next", 1, 2, 9'h1F1, 1);
    stall = 1'b1; redirect_valid = 1'b1;
    tick(); lit("redir_stall", 1, 2, 9'h1F1, 0);
    redirect_valid = 1'b0;
    tick();
    stall = 1'b0;
    tick(); lit("rs_t3", 1, 3, 389, 1);
    tick(); tick();
    tick(); lit("rs_t2", 1, 2, 9'h1F0, 1);

    // 5: nothing enabled, then only T3
    thread_enable = 4'h0;
    tick(); lit("idle0", 0, 2, 9'h1F0, 1);
    tick(); lit("idle1", 0, 2, 9'h1F0, 1);
    thread_enable = 4'b1000;
    tick(); lit("solo0", 1, 3, 390, 1);
    tick(); lit("solo1", 1, 3, 391, 1);
    tick(); lit("solo2", 1, 3, 392, 1);

    // 6: wrap at the top of the address space, then reset mid-run
    redirect_valid = 1'b1; redirect_thread = 2'd3; redirect_pc = 9'd511;
    tick(); lit("wrap0", 1, 3, 511, 1);
    redirect_valid = 1'b0;
    tick(); lit("wrap1", 1, 3, 0, 1);
    reset = 1'b1;
    #1 lit("reset_en", 1, 3, 0, 0);
    tick(); lit("rst_mid", 0, 0, 0, 0);
    reset = 1'b0; thread_enable = 4'hF;
    tick(); lit("rst_b0", 1, 0, 0, 1);
    tick(); lit("rst_b1", 1, 1, 128, 1);

    // Mixed vectors, checked by the model only
    for (int i = 0; i < 12; i++) begin
      thread_enable = vecs[i].en; thread_block = vecs[i].blk; stall = vecs[i].st;
      redirect_valid = vecs[i].rv; redirect_thread = vecs[i].rt;
      redirect_pc = vecs[i].rp;
      tick(); tick();
    end
    redirect_valid = 1'b0; stall = 1'b0;
    tick(); tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
